// File: rtl/fpadd_share_pkg.sv
// Shared types for the fpadder sharing controller: FSM states and response payload.
package fpadd_share_pkg;

   localparam int unsigned FP_W     = 32;
   localparam int unsigned ID_MAX_W = 4;

   typedef enum logic [1:0] {
      WAIT   = 2'd0,
      SEND_A = 2'd1,
      SEND_B = 2'd2
   } state_e;

   typedef struct packed {
      logic [ID_MAX_W-1:0] id;
      logic [FP_W-1:0]     sum;
   } rsp_t;

endpackage

// File: rtl/fpadd_rsp_fifo.sv
// Two-entry response FIFO; entry 0 is always the head so the outputs come straight from flops.
module fpadd_rsp_fifo
   import fpadd_share_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       push,
   input  logic       pop,
   input  rsp_t       din,
   output rsp_t       head,
   output logic       valid,
   output logic [1:0] count
);

   rsp_t       e0_q, e0_d;
   rsp_t       e1_q, e1_d;
   logic [1:0] count_q, count_d;
   logic       valid_q, valid_d;
   logic [1:0] wr_slot;

   // Pop shifts entry 1 into the head; a push lands in the first free slot after that shift.
   always_comb begin
      e0_d    = e0_q;
      e1_d    = e1_q;
      wr_slot = count_q - 2'(pop);
      count_d = count_q + 2'(push) - 2'(pop);
      if (pop) begin
         e0_d = e1_q;
      end
      if (push) begin
         if (wr_slot == 2'd0) begin
            e0_d = din;
         end else begin
            e1_d = din;
         end
      end
      valid_d = (count_d != 2'd0);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         e0_q    <= '0;
         e1_q    <= '0;
         count_q <= 2'd0;
         valid_q <= 1'b0;
      end else begin
         e0_q    <= e0_d;
         e1_q    <= e1_d;
         count_q <= count_d;
         valid_q <= valid_d;
      end
   end

   assign head  = e0_q;
   assign valid = valid_q;
   assign count = count_q;

endmodule

// File: rtl/fpadd_share_ctrl.sv
// Shares one serial-operand fpadder among N_REQ requesters with round-robin grants
// and a tagged two-entry response queue.
module fpadd_share_ctrl
   import fpadd_share_pkg::*;
#(
   parameter  int unsigned N_REQ = 4,
   localparam int unsigned ID_W  = $clog2(N_REQ)
) (
   input  logic                  clock,
   input  logic                  nreset,
   input  logic [N_REQ-1:0]      req_valid,
   output logic [N_REQ-1:0]      req_ready,
   input  logic [N_REQ*FP_W-1:0] req_a,
   input  logic [N_REQ*FP_W-1:0] req_b,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [ID_W-1:0]       rsp_id,
   output logic [FP_W-1:0]       rsp_sum,
   output logic [FP_W-1:0]       add_a,
   input  logic [FP_W-1:0]       add_sum,
   input  logic                  add_ready
);

   state_e          state_q, state_d;
   logic            inflight_q, inflight_d;
   logic [ID_W-1:0] cur_id_q, cur_id_d;
   logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
   logic [FP_W-1:0] b_hold_q, b_hold_d;
   logic [FP_W-1:0] add_a_q, add_a_d;
   logic            err_q, err_d;

   logic            push, pop, eligible, found;
   logic [1:0]      fifo_count, occ_next;
   logic [ID_W-1:0] gnt;
   logic [ID_W:0]   idx;
   rsp_t            push_data, head;
   logic            fifo_valid;

   // Round-robin pick: first valid requester at or after rr_ptr, wrapping.
   always_comb begin
      found = 1'b0;
      gnt   = '0;
      idx   = '0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         idx = (ID_W+1)'(rr_ptr_q) + (ID_W+1)'(i);
         if (idx >= (ID_W+1)'(N_REQ)) begin
            idx = idx - (ID_W+1)'(N_REQ);
         end
         if (!found && req_valid[idx[ID_W-1:0]]) begin
            found = 1'b1;
            gnt   = idx[ID_W-1:0];
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      inflight_d = inflight_q;
      cur_id_d   = cur_id_q;
      rr_ptr_d   = rr_ptr_q;
      b_hold_d   = b_hold_q;
      add_a_d    = '0;
      err_d      = err_q;
      req_ready  = '0;
      push       = 1'b0;
      push_data  = '{id: ID_MAX_W'(cur_id_q), sum: add_sum};
      pop        = fifo_valid && rsp_ready;
      occ_next   = fifo_count;
      eligible   = 1'b0;

      unique case (state_q)
         WAIT: begin
            if (add_ready) begin
               state_d  = SEND_A;
               push     = inflight_q;
               // Grant only if a slot is guaranteed when this op's result returns.
               occ_next = fifo_count + 2'(push) - 2'(pop);
               eligible = (occ_next <= 2'd1);
               if (eligible && found) begin
                  req_ready[gnt] = 1'b1;
                  add_a_d        = req_a[gnt*FP_W +: FP_W];
                  b_hold_d       = req_b[gnt*FP_W +: FP_W];
                  cur_id_d       = gnt;
                  inflight_d     = 1'b1;
                  rr_ptr_d       = (gnt == ID_W'(N_REQ-1)) ? '0 : gnt + ID_W'(1);
               end else begin
                  inflight_d = 1'b0;
                  b_hold_d   = '0;
               end
            end
         end
         SEND_A: begin
            add_a_d = b_hold_q;
            state_d = SEND_B;
            if (add_ready) begin
               err_d = 1'b1;
            end
         end
         SEND_B: begin
            state_d = WAIT;
            if (add_ready) begin
               err_d = 1'b1;
            end
         end
         default: state_d = WAIT;
      endcase
   end

   always_ff @(posedge clock or negedge nreset) begin
      if (!nreset) begin
         state_q    <= WAIT;
         inflight_q <= 1'b0;
         cur_id_q   <= '0;
         rr_ptr_q   <= '0;
         b_hold_q   <= '0;
         add_a_q    <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         inflight_q <= inflight_d;
         cur_id_q   <= cur_id_d;
         rr_ptr_q   <= rr_ptr_d;
         b_hold_q   <= b_hold_d;
         add_a_q    <= add_a_d;
         err_q      <= err_d;
      end
   end

   fpadd_rsp_fifo u_fifo (
      .clk   (clock),
      .rst_n (nreset),
      .push  (push),
      .pop   (pop),
      .din   (push_data),
      .head  (head),
      .valid (fifo_valid),
      .count (fifo_count)
   );

   assign add_a     = add_a_q;
   assign rsp_valid = fifo_valid;
   assign rsp_id    = ID_W'(head.id);
   assign rsp_sum   = head.sum;

endmodule
